// File: rtl/cabac_enc_pkg.sv
// Shared types and constants for the CABAC bypass-bin encoder.
// Optional feature macro used by the encoder: EP_FIRST_BIT_SKIP_EN.
package cabac_enc_pkg;

  localparam int unsigned LOW_W_DEF   = 10;
  localparam int unsigned RANGE_W_DEF = 9;
  localparam int unsigned OUTST_W_DEF = 16;

  localparam int unsigned QUARTER = 256;
  localparam int unsigned HALF    = 2 * QUARTER;
  localparam int unsigned FULL    = 4 * QUARTER;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_B,
    ST_EMIT_OUT,
    ST_FLUSH2,
    ST_FLUSH3
  } state_e;

endpackage

// File: rtl/ep_bit_emitter.sv
// PutBit engine: emits b followed by the pending outstanding !b bits over
// the valid/ready bit port, and owns the outstanding-bit counter.
module ep_bit_emitter
  import cabac_enc_pkg::*;
#(
  parameter int unsigned OUTST_W = OUTST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               put_req,
  input  logic               put_bit,
  input  logic               put_skip,
  input  logic               inc_outst,
  input  logic               bit_ready,
  output logic               busy,
  output logic               fin,
  output logic               bit_valid,
  output logic               bit_out,
  output logic [OUTST_W-1:0] outst,
  output logic               overflow
);

  localparam logic [OUTST_W-1:0] OUTST_MAX = '1;
  localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);

  state_e             state;
  state_e             state_nxt;
  logic               b_q;
  logic [OUTST_W-1:0] outst_q;
  logic               ovf_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (put_req) begin
          if (!put_skip)           state_nxt = ST_EMIT_B;
          else if (outst_q != '0)  state_nxt = ST_EMIT_OUT;
        end
      end
      ST_EMIT_B: begin
        if (bit_ready) state_nxt = (outst_q != '0) ? ST_EMIT_OUT : ST_IDLE;
      end
      ST_EMIT_OUT: begin
        // <= 1 rather than == 1 so a corrupted (saturated) count can never hang here
        if (bit_ready && outst_q <= OUTST_ONE) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_EMIT_B) || (state == ST_EMIT_OUT);
    bit_valid = busy;
    bit_out   = (state == ST_EMIT_OUT) ? ~b_q : b_q;
    fin       = ((state == ST_EMIT_B)   && bit_ready && (outst_q == '0)) ||
                ((state == ST_EMIT_OUT) && bit_ready && (outst_q <= OUTST_ONE));
    outst     = outst_q;
    overflow  = ovf_q;
  end

  // Counter: increments from the top never coincide with emission decrements.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_q     <= 1'b0;
      outst_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (put_req) b_q <= put_bit;
      if (clear) begin
        outst_q <= '0;
      end else if (inc_outst) begin
        if (outst_q == OUTST_MAX) ovf_q   <= 1'b1;
        else                      outst_q <= outst_q + OUTST_ONE;
      end else if (state == ST_EMIT_OUT && bit_ready && outst_q != '0) begin
        outst_q <= outst_q - OUTST_ONE;
      end
    end
  end

endmodule

// File: rtl/encode_bin_ep.sv
// CABAC bypass-bin encoder: low-register update, IDLE arbitration and flush.
// Optional macro EP_FIRST_BIT_SKIP_EN suppresses the first PutBit's b bit.
module encode_bin_ep
  import cabac_enc_pkg::*;
#(
  parameter int unsigned LOW_W   = LOW_W_DEF,
  parameter int unsigned RANGE_W = RANGE_W_DEF,
  parameter int unsigned OUTST_W = OUTST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               bin_in,
  input  logic [RANGE_W-1:0] range_in,
  input  logic               flush,
  output logic               bit_valid,
  output logic               bit_out,
  input  logic               bit_ready,
  output logic               done,
  output logic [LOW_W-1:0]   low_out,
  output logic [OUTST_W-1:0] outst_out,
  output logic               overflow
);

  localparam int unsigned S_W = LOW_W + 2;

  state_e           state;
  state_e           state_nxt;
  logic [LOW_W-1:0] low_q;
  logic [LOW_W-1:0] low_nxt;
  logic [S_W-1:0]   s;
  logic             flushing;
  logic             done_q;
  logic             idle_ok;
  logic             accept;
  logic             do_init;
  logic             do_flush;
  logic             flush_end;
  logic             s_hi;
  logic             s_lo;
  logic             put_req;
  logic             put_bit;
  logic             put_skip;
  logic             emit_busy;
  logic             emit_fin;
  logic             emit_valid;
  logic             emit_bit;

  // Arbitration in IDLE: init > flush > bin.
  always_comb begin
    idle_ok   = (state == ST_IDLE) && !emit_busy && !flushing;
    do_init   = idle_ok && init;
    do_flush  = idle_ok && !init && flush;
    accept    = in_valid && in_ready;
    flush_end = (state == ST_FLUSH3) && bit_ready;
    s         = (S_W'(low_q) << 1) + (bin_in ? S_W'(range_in) : S_W'(0));
    s_hi      = s >= S_W'(FULL);
    s_lo      = s <  S_W'(HALF);
    if (s_hi)      low_nxt = LOW_W'(s - S_W'(FULL));
    else if (s_lo) low_nxt = LOW_W'(s);
    else           low_nxt = LOW_W'(s - S_W'(HALF));
    put_req   = (accept && (s_hi || s_lo)) || do_flush;
    put_bit   = do_flush ? low_q[LOW_W-1] : s_hi;
  end

`ifdef EP_FIRST_BIT_SKIP_EN
  logic first_q;

  always_ff @(posedge clk) begin
    if (rst || do_init || flush_end) first_q <= 1'b1;
    else if (put_req)                first_q <= 1'b0;
  end

  assign put_skip = first_q;
`else
  assign put_skip = 1'b0;
`endif

  ep_bit_emitter #(.OUTST_W(OUTST_W)) u_emit (
    .clk       (clk),
    .rst       (rst),
    .clear     (do_init || flush_end),
    .put_req   (put_req),
    .put_bit   (put_bit),
    .put_skip  (put_skip),
    .inc_outst (accept && !s_hi && !s_lo),
    .bit_ready (bit_ready),
    .busy      (emit_busy),
    .fin       (emit_fin),
    .bit_valid (emit_valid),
    .bit_out   (emit_bit),
    .outst     (outst_out),
    .overflow  (overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (flushing && (emit_fin || !emit_busy)) state_nxt = ST_FLUSH2;
      ST_FLUSH2: if (bit_ready) state_nxt = ST_FLUSH3;
      ST_FLUSH3: if (bit_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) && !emit_busy && !flushing && !init && !flush;
    bit_valid = emit_valid || (state == ST_FLUSH2) || (state == ST_FLUSH3);
    case (state)
      ST_FLUSH2: bit_out = low_q[LOW_W-2];
      ST_FLUSH3: bit_out = 1'b1;
      default:   bit_out = emit_bit;
    endcase
    done      = done_q;
    low_out   = low_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_q    <= '0;
      flushing <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= flush_end;
      if (do_init || flush_end) low_q <= '0;
      else if (accept)          low_q <= low_nxt;
      if (do_flush)                  flushing <= 1'b1;
      else if (state_nxt == ST_FLUSH2) flushing <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encode_bin_ep.sv
// Directed bench for encode_bin_ep: vector table plus multi-cycle sequences.
module tb_encode_bin_ep;

  logic       clk = 1'b0;
  logic       rst, init, in_valid, bin_in, flush, bit_ready;
  logic [8:0] range_in;
  logic       in_ready, bit_valid, bit_out, done, overflow;
  logic [9:0] low_out;
  logic [15:0] outst_out;
  logic       in_ready2, bit_valid2, bit_out2, done2, overflow2;
  logic [9:0] low_out2;
  logic [1:0] outst_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encode_bin_ep u_dut (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .range_in(range_in), .flush(flush), .bit_valid(bit_valid),
    .bit_out(bit_out), .bit_ready(bit_ready), .done(done), .low_out(low_out),
    .outst_out(outst_out), .overflow(overflow)
  );

  encode_bin_ep #(.OUTST_W(2)) u_ovf (
    .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_ready(in_ready2),
    .bin_in(bin_in), .range_in(range_in), .flush(flush), .bit_valid(bit_valid2),
    .bit_out(bit_out2), .bit_ready(bit_ready), .done(done2), .low_out(low_out2),
    .outst_out(outst_out2), .overflow(overflow2)
  );

  typedef struct {
    logic       bin;
    int         range;
    int         exp_low;
    int         exp_outst;
    int         exp_n;
    logic [3:0] exp_bits;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic send_bin(input logic b, input int r);
    in_valid = 1'b1;
    bin_in   = b;
    range_in = 9'(r);
    #1;
    chk("in_ready_before_bin", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  // Gather transferred bits until the engine is idle again.
  task automatic collect(output int n, output logic [15:0] bits);
    bit finished;
    n = 0;
    bits = '0;
    finished = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (!bit_valid && in_ready) begin
        finished = 1'b1;
        break;
      end
      if (bit_valid && bit_ready && n < 16) begin
        bits[n] = bit_out;
        n++;
      end
      tick();
    end
    if (!finished) chk("collect_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int          n;
    logic [15:0] bits;

    vecs[0] = '{1'b1, 256, 256, 0, 1, 4'b0000};
    vecs[1] = '{1'b1, 256, 256, 1, 0, 4'b0000};
    vecs[2] = '{1'b0, 256,   0, 2, 0, 4'b0000};
    vecs[3] = '{1'b0, 256,   0, 0, 3, 4'b0110};
    vecs[4] = '{1'b1, 256, 256, 0, 1, 4'b0000};
    vecs[5] = '{1'b1, 510, 510, 1, 0, 4'b0000};
    vecs[6] = '{1'b1, 510, 506, 0, 2, 4'b0001};

    rst = 1'b1; init = 1'b0; in_valid = 1'b0; bin_in = 1'b0;
    range_in = 9'd256; flush = 1'b0; bit_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_low",       32'(low_out),   32'd0);
    chk("rst_outst",     32'(outst_out), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);

    // init together with a bin: init wins, bin dropped
    init = 1'b1; in_valid = 1'b1; bin_in = 1'b1; range_in = 9'd300;
    #1;
    chk("init_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    init = 1'b0; in_valid = 1'b0;
    chk("init_bin_dropped_low", 32'(low_out), 32'd0);

    foreach (vecs[i]) begin
      send_bin(vecs[i].bin, vecs[i].range);
      chk($sformatf("v%0d_low", i), 32'(low_out), 32'(vecs[i].exp_low));
      chk($sformatf("v%0d_valid_t1", i), 32'(bit_valid), 32'(vecs[i].exp_n > 0));
      collect(n, bits);
      chk($sformatf("v%0d_nbits", i), 32'(n), 32'(vecs[i].exp_n));
      chk($sformatf("v%0d_bits", i), 32'(bits), 32'(vecs[i].exp_bits));
      chk($sformatf("v%0d_outst", i), 32'(outst_out), 32'(vecs[i].exp_outst));
    end

    // Backpressure during a PutBit with two outstanding bits
    pulse_init();
    send_bin(1'b1, 256); collect(n, bits);
    send_bin(1'b1, 256); collect(n, bits);
    send_bin(1'b0, 256); collect(n, bits);
    chk("stall_pre_outst", 32'(outst_out), 32'd2);
    bit_ready = 1'b0;
    send_bin(1'b0, 256);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", 32'(bit_valid), 32'd1);
      chk("stall_bit",   32'(bit_out),   32'd0);
      chk("stall_ready", 32'(in_ready),  32'd0);
      tick();
    end
    bit_ready = 1'b1;
    collect(n, bits);
    chk("stall_nbits", 32'(n), 32'd3);
    chk("stall_bits",  32'(bits), 32'b0110);
    chk("stall_outst", 32'(outst_out), 32'd0);

    // Flush from low=384, no outstanding: bits 0,1,1 then done
    send_bin(1'b1, 384);
    collect(n, bits);
    chk("fa_low", 32'(low_out), 32'd384);
    chk("fa_pre_bits", 32'(bits), 32'd0);
    flush = 1'b1;
    #1;
    chk("fa_flush_blocks_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    collect(n, bits);
    chk("fa_nbits", 32'(n), 32'd3);
    chk("fa_bits",  32'(bits), 32'b110);
    chk("fa_done",  32'(done), 32'd1);
    chk("fa_low_cleared", 32'(low_out), 32'd0);
    tick();
    chk("fa_done_pulse", 32'(done), 32'd0);

    // Flush with one outstanding bit: 0, 1 (outstanding), low[8]=1, 1
    pulse_init();
    send_bin(1'b1, 256); collect(n, bits);
    send_bin(1'b1, 256); collect(n, bits);
    chk("fb_outst", 32'(outst_out), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    collect(n, bits);
    chk("fb_nbits", 32'(n), 32'd4);
    chk("fb_bits",  32'(bits), 32'b1110);
    chk("fb_done",  32'(done), 32'd1);
    chk("fb_outst_cleared", 32'(outst_out), 32'd0);
    tick();

    // Reset while emitting outstanding bits
    pulse_init();
    send_bin(1'b1, 256); collect(n, bits);
    send_bin(1'b1, 256); collect(n, bits);
    send_bin(1'b0, 256); collect(n, bits);
    send_bin(1'b0, 256);
    chk("er_emit_b", 32'(bit_out), 32'd0);
    tick();
    chk("er_emit_out_valid", 32'(bit_valid), 32'd1);
    chk("er_emit_out_bit",   32'(bit_out),   32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("er_valid", 32'(bit_valid), 32'd0);
    chk("er_low",   32'(low_out),   32'd0);
    chk("er_outst", 32'(outst_out), 32'd0);
    chk("er_ready", 32'(in_ready),  32'd1);

    // Saturation on the 2-bit counter instance
    chk("ov_clear", 32'(overflow2), 32'd0);
    send_bin(1'b1, 256); collect(n, bits);
    for (int k = 1; k <= 4; k++) begin
      send_bin(1'b1, 256);
      chk($sformatf("ov_flag_%0d", k), 32'(overflow2), 32'(k == 4));
    end
    chk("ov_outst_sat", 32'(outst_out2), 32'd3);
    chk("ov_main_outst", 32'(outst_out), 32'd4);
    pulse_init();
    chk("ov_sticky_init", 32'(overflow2), 32'd1);
    chk("ov_init_outst", 32'(outst_out2), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ov_rst_clear", 32'(overflow2), 32'd0);
    chk("main_no_overflow", 32'(overflow), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
